// File: rtl/btree_pkg.sv
// Shared definitions for the B-tree search engine.
// FSM state constants and helpers that derive the packed node word layout
// {leaf, count, children[KEYS:0], data[KEYS-1:0], keys[KEYS-1:0]} (keys at LSB).
package btree_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;

  // Width of the per-node valid-key count field.
  function automatic int unsigned cnt_bits(input int unsigned keys);
    return $clog2(keys + 1);
  endfunction

  function automatic int unsigned data_off(input int unsigned kb, input int unsigned keys);
    return keys * kb;
  endfunction

  function automatic int unsigned child_off(input int unsigned kb, input int unsigned db,
                                            input int unsigned keys);
    return keys * (kb + db);
  endfunction

  function automatic int unsigned count_off(input int unsigned kb, input int unsigned db,
                                            input int unsigned ab, input int unsigned keys);
    return child_off(kb, db, keys) + (keys + 1) * ab;
  endfunction

  function automatic int unsigned leaf_off(input int unsigned kb, input int unsigned db,
                                           input int unsigned ab, input int unsigned keys);
    return count_off(kb, db, ab, keys) + cnt_bits(keys);
  endfunction

  function automatic int unsigned node_bits(input int unsigned kb, input int unsigned db,
                                            input int unsigned ab, input int unsigned keys);
    return leaf_off(kb, db, ab, keys) + 1;
  endfunction

endpackage

// File: rtl/btree_find_if.sv
// Bus bundle for btree_find: node write port, search handshake and held results.
// master: drives writes/start/key, observes results. slave: the search engine.
interface btree_find_if
  import btree_pkg::*;
#(
  parameter int unsigned KEY_BITS  = 4,
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned KEYS      = 3,
  parameter int unsigned MAX_DEPTH = 8
) ();

  localparam int unsigned NODE_BITS = node_bits(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS);
  localparam int unsigned LVL_BITS  = $clog2(MAX_DEPTH + 1);

  logic                 wEnable;
  logic [ADDR_BITS-1:0] wAddress;
  logic [NODE_BITS-1:0] wNode;
  logic                 start;
  logic [KEY_BITS-1:0]  key;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [DATA_BITS-1:0] data;
  logic [LVL_BITS-1:0]  levels;
  logic                 error;

  modport master (
    output wEnable, wAddress, wNode, start, key,
    input  busy, done, found, data, levels, error
  );

  modport slave (
    input  wEnable, wAddress, wNode, start, key,
    output busy, done, found, data, levels, error
  );

endinterface

// File: rtl/btree_node_compare.sv
// Combinational evaluation of one node word against a search key.
// Ports: node_i/key_i in; match_o, match_data_o, child_idx_o (valid keys < key),
// leaf_o, count_err_o (count > KEYS) out.
module btree_node_compare
  import btree_pkg::*;
#(
  parameter int unsigned KEY_BITS  = 4,
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned KEYS      = 3
) (
  input  logic [node_bits(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS)-1:0] node_i,
  input  logic [KEY_BITS-1:0]                                        key_i,
  output logic                                                       match_o,
  output logic [DATA_BITS-1:0]                                       match_data_o,
  output logic [cnt_bits(KEYS)-1:0]                                  child_idx_o,
  output logic                                                       leaf_o,
  output logic                                                       count_err_o
);

  localparam int unsigned CNT_W     = cnt_bits(KEYS);
  localparam int unsigned D_OFF     = data_off(KEY_BITS, KEYS);
  localparam int unsigned CH_OFF    = child_off(KEY_BITS, DATA_BITS, KEYS);
  localparam int unsigned C_OFF     = count_off(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS);
  localparam int unsigned L_OFF     = leaf_off(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS);

  logic [KEY_BITS-1:0]  keys  [KEYS];
  logic [DATA_BITS-1:0] datas [KEYS];
  logic [CNT_W-1:0]     count;

  // Child pointers are selected by the parent using child_idx_o.
  wire unused_children = ^node_i[CH_OFF +: (KEYS + 1) * ADDR_BITS];

  for (genvar g = 0; g < KEYS; g++) begin : g_field
    assign keys[g]  = node_i[g * KEY_BITS +: KEY_BITS];
    assign datas[g] = node_i[D_OFF + g * DATA_BITS +: DATA_BITS];
  end

  assign count       = node_i[C_OFF +: CNT_W];
  assign leaf_o      = node_i[L_OFF];
  assign count_err_o = (count > CNT_W'(KEYS));

  // Only slots below count participate in matching and child selection.
  always_comb begin
    match_o      = 1'b0;
    match_data_o = '0;
    child_idx_o  = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (CNT_W'(i) < count) begin
        if (!match_o && keys[i] == key_i) begin
          match_o      = 1'b1;
          match_data_o = datas[i];
        end
        if (keys[i] < key_i) begin
          child_idx_o = child_idx_o + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/btree_find.sv
// B-tree search engine: node store with write port plus an IDLE/FETCH/COMPARE walker.
// Ports: clock, reset (async, active-high), bus (btree_find_if.slave) carrying the
// write port, start/key handshake and held results busy/done/found/data/levels/error.
module btree_find
  import btree_pkg::*;
#(
  parameter int unsigned KEY_BITS  = 4,
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned KEYS      = 3,
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned ROOT      = 0
) (
  input logic         clock,
  input logic         reset,
  btree_find_if.slave bus
);

  localparam int unsigned NODE_BITS = node_bits(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS);
  localparam int unsigned CNT_W     = cnt_bits(KEYS);
  localparam int unsigned LVL_W     = $clog2(MAX_DEPTH + 1);
  localparam int unsigned CH_OFF    = child_off(KEY_BITS, DATA_BITS, KEYS);
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;

  logic [NODE_BITS-1:0] mem_q [DEPTH];
  logic [NODE_BITS-1:0] node_q;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [KEY_BITS-1:0]  key_q, key_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [LVL_W-1:0]     levels_q, levels_d;
  logic                 error_q, error_d;

  logic                 cmp_match, cmp_leaf, cmp_cnt_err;
  logic [DATA_BITS-1:0] cmp_data;
  logic [CNT_W-1:0]     cmp_child_idx;
  logic [ADDR_BITS-1:0] child_addr;
  logic [LVL_W-1:0]     lvl_n;

  // Node store: nonblocking read and write in one block give read-before-write.
  always_ff @(posedge clock) begin
    if (bus.wEnable) begin
      mem_q[bus.wAddress] <= bus.wNode;
    end
    if (state_q == S_FETCH) begin
      node_q <= mem_q[addr_q];
    end
  end

  btree_node_compare #(
    .KEY_BITS (KEY_BITS),
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS),
    .KEYS     (KEYS)
  ) u_cmp (
    .node_i      (node_q),
    .key_i       (key_q),
    .match_o     (cmp_match),
    .match_data_o(cmp_data),
    .child_idx_o (cmp_child_idx),
    .leaf_o      (cmp_leaf),
    .count_err_o (cmp_cnt_err)
  );

  // Child pointer select.
  always_comb begin
    child_addr = '0;
    for (int unsigned j = 0; j <= KEYS; j++) begin
      if (cmp_child_idx == CNT_W'(j)) begin
        child_addr = node_q[CH_OFF + j * ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    key_d    = key_q;
    lvl_d    = lvl_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    data_d   = data_q;
    levels_d = levels_q;
    error_d  = error_q;
    lvl_n    = lvl_q + LVL_W'(1);
    case (state_q)
      S_IDLE: begin
        // busy_q is still set in the done cycle; a start there is dropped.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (bus.start) begin
          key_d   = bus.key;
          addr_d  = ADDR_BITS'(ROOT);
          lvl_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        lvl_d = lvl_n;
        if (!cmp_cnt_err && !cmp_match && !cmp_leaf && lvl_n != LVL_W'(MAX_DEPTH)) begin
          addr_d  = child_addr;
          state_d = S_FETCH;
        end else begin
          // Past the first three priorities the only remaining cause is depth.
          done_d   = 1'b1;
          levels_d = lvl_n;
          found_d  = !cmp_cnt_err && cmp_match;
          data_d   = (!cmp_cnt_err && cmp_match) ? cmp_data : '0;
          error_d  = cmp_cnt_err || (!cmp_match && !cmp_leaf);
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      key_q    <= '0;
      lvl_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      data_q   <= '0;
      levels_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      key_q    <= key_d;
      lvl_q    <= lvl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      data_q   <= data_d;
      levels_q <= levels_d;
      error_q  <= error_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.data   = data_q;
  assign bus.levels = levels_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_btree_find.sv
// Self-checking bench for btree_find: directed scenarios plus random trees,
// all compared against a plain array-walking reference search.
module tb_btree_find;

  localparam int unsigned KB   = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned AB   = 4;
  localparam int unsigned KEYS = 4;   // count field is 3 bits, so count>KEYS is encodable
  localparam int unsigned MAXD = 8;
  localparam int unsigned ROOT = 0;
  localparam int unsigned NN   = 1 << AB;
  localparam int unsigned CW   = $clog2(KEYS + 1);
  localparam int unsigned NB   = 1 + CW + (KEYS + 1) * AB + KEYS * (DB + KB);

  logic clock;
  logic reset;

  btree_find_if #(.KEY_BITS(KB), .DATA_BITS(DB), .ADDR_BITS(AB), .KEYS(KEYS), .MAX_DEPTH(MAXD)) bus ();

  btree_find #(
    .KEY_BITS(KB), .DATA_BITS(DB), .ADDR_BITS(AB), .KEYS(KEYS), .MAX_DEPTH(MAXD), .ROOT(ROOT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference store contents.
  int m_leaf [NN];
  int m_cnt  [NN];
  int m_key  [NN][KEYS];
  int m_dat  [NN][KEYS];
  int m_ch   [NN][KEYS+1];

  int n_checks = 0;
  int n_fail   = 0;
  int pend_addr = 0;
  logic [NB-1:0] pend_word;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_node(input int a, input int leaf, input int cnt,
                          input int k[KEYS], input int d[KEYS], input int c[KEYS+1]);
    m_leaf[a] = leaf;
    m_cnt[a]  = cnt;
    for (int i = 0; i < KEYS; i++) begin
      m_key[a][i] = k[i];
      m_dat[a][i] = d[i];
    end
    for (int j = 0; j <= KEYS; j++) m_ch[a][j] = c[j];
  endtask

  function automatic logic [NB-1:0] enc(input int a);
    logic [NB-1:0] w;
    w = '0;
    for (int i = 0; i < KEYS; i++) begin
      w[i*KB +: KB]              = KB'(m_key[a][i]);
      w[KEYS*KB + i*DB +: DB]    = DB'(m_dat[a][i]);
    end
    for (int j = 0; j <= KEYS; j++) w[KEYS*(KB+DB) + j*AB +: AB] = AB'(m_ch[a][j]);
    w[KEYS*(KB+DB) + (KEYS+1)*AB +: CW] = CW'(m_cnt[a]);
    w[NB-1] = (m_leaf[a] != 0);
    return w;
  endfunction

  task automatic load_node(input int a);
    @(negedge clock);
    bus.wEnable  = 1'b1;
    bus.wAddress = AB'(a);
    bus.wNode    = enc(a);
    @(negedge clock);
    bus.wEnable  = 1'b0;
  endtask

  // Walk the tree directly from the search rules.
  function automatic void ref_search(input int k, output bit f, output int d,
                                     output int lv, output bit e);
    int a;
    int n;
    bit fin;
    a = ROOT; f = 0; d = 0; lv = 0; e = 0; fin = 0;
    while (!fin) begin
      lv++;
      if (m_cnt[a] > int'(KEYS)) begin
        e = 1; fin = 1;
      end else begin
        for (int i = 0; i < m_cnt[a]; i++) begin
          if (!fin && m_key[a][i] == k) begin
            f = 1; d = m_dat[a][i]; fin = 1;
          end
        end
        if (!fin) begin
          if (m_leaf[a] != 0) begin
            fin = 1;
          end else if (lv == int'(MAXD)) begin
            e = 1; fin = 1;
          end else begin
            n = 0;
            for (int i = 0; i < m_cnt[a]; i++) if (m_key[a][i] < k) n++;
            a = m_ch[a][n];
          end
        end
      end
    end
  endfunction

  // mode 0 plain, 1 start while busy, 2 start in done cycle, 3 write pend_word in FETCH.
  task automatic search(input int k, input int mode, input string tag);
    bit ef, ee;
    int ed, el, cyc;
    ref_search(k, ef, ed, el, ee);
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = KB'(k);
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    check_eq({tag, ".busy"}, 32'(bus.busy), 1);
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (mode == 3 && cyc == 1) begin
        bus.wEnable  = 1'b1;
        bus.wAddress = AB'(pend_addr);
        bus.wNode    = pend_word;
      end
      if (mode == 1 && cyc == 2) begin
        bus.start = 1'b1;
        bus.key   = KB'(k ^ 6);
      end
      @(negedge clock);
      cyc++;
      bus.wEnable = 1'b0;
      bus.start   = 1'b0;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'(2 * el + 1));
    check_eq({tag, ".found"},   32'(bus.found),  32'(ef));
    check_eq({tag, ".data"},    32'(bus.data),   32'(ed));
    check_eq({tag, ".levels"},  32'(bus.levels), 32'(el));
    check_eq({tag, ".error"},   32'(bus.error),  32'(ee));
    if (mode == 2) begin
      bus.start = 1'b1;
      bus.key   = KB'(k);
    end
    @(negedge clock);
    bus.start = 1'b0;
    check_eq({tag, ".idle_after"}, {30'd0, bus.busy, bus.done}, 0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, ".busy"},   32'(bus.busy),   0);
    check_eq({tag, ".done"},   32'(bus.done),   0);
    check_eq({tag, ".found"},  32'(bus.found),  0);
    check_eq({tag, ".data"},   32'(bus.data),   0);
    check_eq({tag, ".levels"}, 32'(bus.levels), 0);
    check_eq({tag, ".error"},  32'(bus.error),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.wEnable  = 1'b0;
    bus.wAddress = '0;
    bus.wNode    = '0;
    bus.start    = 1'b0;
    bus.key      = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;

    // Root hit.
    set_node(0, 1, 3, '{2, 5, 9, 0}, '{1, 6, 7, 0}, '{0, 0, 0, 0, 0});
    load_node(0);
    search(5, 0, "root_hit");
    search(2, 0, "root_first");
    search(9, 0, "root_last");
    search(4, 0, "root_miss");
    search(5, 0, "root_hit2");

    // Reset asserted while in COMPARE.
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = KB'(9);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_cleared("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("rst_mid.no_done", 32'(bus.done), 0);
    end
    search(9, 0, "after_rst");

    // Two-level descent.
    set_node(0, 0, 1, '{8, 0, 0, 0}, '{9, 0, 0, 0}, '{4, 5, 0, 0, 0});
    set_node(4, 1, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0, 0});
    set_node(5, 1, 2, '{10, 12, 0, 0}, '{3, 4, 0, 0}, '{0, 0, 0, 0, 0});
    load_node(0);
    load_node(4);
    load_node(5);
    search(12, 0, "two_hit");
    search(11, 0, "two_miss");
    search(3, 0, "two_left");
    search(8, 0, "two_root");

    // Partial node with a stale key slot.
    set_node(0, 1, 1, '{3, 7, 0, 0}, '{2, 5, 0, 0}, '{0, 0, 0, 0, 0});
    load_node(0);
    search(7, 1, "partial_stale");
    search(3, 2, "partial_hit");
    repeat (3) @(negedge clock);
    load_node(6);
    check_eq("held.found",  32'(bus.found),  1);
    check_eq("held.data",   32'(bus.data),   2);
    check_eq("held.levels", 32'(bus.levels), 1);

    // Self loop runs into the depth limit; oversized count is a format error.
    set_node(0, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0, 0});
    load_node(0);
    search(5, 0, "self_loop");
    set_node(0, 1, 5, '{5, 6, 7, 8}, '{1, 2, 3, 4}, '{0, 0, 0, 0, 0});
    load_node(0);
    search(5, 0, "count_err");

    // Write to the root during its FETCH: old word seen, new word next time.
    set_node(0, 1, 3, '{2, 5, 9, 0}, '{1, 12, 7, 0}, '{0, 0, 0, 0, 0});
    pend_word = enc(0);
    pend_addr = 0;
    set_node(0, 1, 3, '{2, 5, 9, 0}, '{1, 6, 7, 0}, '{0, 0, 0, 0, 0});
    load_node(0);
    search(5, 3, "collide_old");
    set_node(0, 1, 3, '{2, 5, 9, 0}, '{1, 12, 7, 0}, '{0, 0, 0, 0, 0});
    search(5, 0, "collide_new");

    // Random trees.
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < int'(NN); a++) begin
        int leaf, cnt, n, idx, v;
        int k[KEYS];
        int d[KEYS];
        int c[KEYS+1];
        bit [15:0] used;
        leaf = ($urandom_range(0, 2) == 0) ? 1 : 0;
        if ($urandom_range(0, 15) == 0) cnt = int'($urandom_range(KEYS + 1, (1 << CW) - 1));
        else cnt = int'($urandom_range(0, KEYS));
        used = '0;
        n = 0;
        while (n < cnt && n < int'(KEYS)) begin
          v = int'($urandom_range(0, 15));
          if (!used[v]) begin
            used[v] = 1'b1;
            n++;
          end
        end
        idx = 0;
        for (int s = 0; s < 16; s++) begin
          if (used[s]) begin
            k[idx] = s;
            idx++;
          end
        end
        for (int s = idx; s < int'(KEYS); s++) k[s] = int'($urandom_range(0, 15));
        for (int s = 0; s < int'(KEYS); s++) d[s] = int'($urandom_range(0, 15));
        for (int s = 0; s <= int'(KEYS); s++) c[s] = int'($urandom_range(0, NN - 1));
        set_node(a, leaf, cnt, k, d, c);
        load_node(a);
      end
      for (int q = 0; q < 4; q++) begin
        search(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
